// File: rtl/rs_enc.sv
// Systematic Reed-Solomon encoder: passes message beats through, then appends
// ROOTS_NUM parity symbols. Define RS_ENC_LEN_CHECK_EN to build the message length check.
package gf_pkg;
    localparam int SYMB_WIDTH        = 8;
    localparam logic [SYMB_WIDTH:0] POLY = 9'h11D;
    localparam int N_LEN             = 255;
    localparam int K_LEN             = 239;
    localparam int ROOTS_NUM         = N_LEN - K_LEN;
    localparam int FIRST_ROOT        = 1;
    localparam int BUS_WIDTH_IN_SYMB = 4;

    typedef logic [SYMB_WIDTH-1:0] symb_t;
    typedef logic [ROOTS_NUM:0][SYMB_WIDTH-1:0] gen_t;

    function automatic symb_t gf_mult(input symb_t a, input symb_t b);
        symb_t p, aa, bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int i = 0; i < SYMB_WIDTH; i++) begin
            if (bb[0]) p = p ^ aa;
            bb = bb >> 1;
            aa = aa[SYMB_WIDTH-1] ? ((aa << 1) ^ POLY[SYMB_WIDTH-1:0]) : (aa << 1);
        end
        return p;
    endfunction

    function automatic symb_t gf_alpha_pow(input int n);
        symb_t x;
        x = symb_t'(1);
        for (int i = 0; i < n; i++) x = gf_mult(x, symb_t'(2));
        return x;
    endfunction

    // g(x) = prod (x + alpha^i), built up one root at a time; g[ROOTS_NUM] ends up 1
    function automatic gen_t gen_poly();
        gen_t  g;
        symb_t root;
        g    = '0;
        g[0] = symb_t'(1);
        for (int i = 0; i < ROOTS_NUM; i++) begin
            root = gf_alpha_pow(FIRST_ROOT + i);
            for (int j = ROOTS_NUM; j > 0; j--) g[j] = g[j-1] ^ gf_mult(g[j], root);
            g[0] = gf_mult(g[0], root);
        end
        return g;
    endfunction
endpackage

// One serial LFSR step for a single lane; a lane with en=0 passes the state through.
module rs_enc_lane import gf_pkg::*; (
    input  logic                                  en,
    input  logic [SYMB_WIDTH-1:0]                 d,
    input  logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]  r_in,
    output logic [ROOTS_NUM-1:0][SYMB_WIDTH-1:0]  r_out
);
    localparam gen_t GEN = gen_poly();

    logic [SYMB_WIDTH-1:0] fb;

    always_comb begin
        fb    = d ^ r_in[ROOTS_NUM-1];
        r_out = r_in;
        if (en) begin
            r_out[0] = gf_mult(fb, GEN[0]);
            for (int j = 1; j < ROOTS_NUM; j++) r_out[j] = r_in[j-1] ^ gf_mult(fb, GEN[j]);
        end
    end
endmodule

module rs_enc import gf_pkg::*; (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic                                    s_tvalid,
    output logic                                    s_tready,
    input  logic [BUS_WIDTH_IN_SYMB*SYMB_WIDTH-1:0] s_tdata,
    input  logic [BUS_WIDTH_IN_SYMB-1:0]            s_tkeep,
    input  logic                                    s_tlast,
    output logic                                    m_tvalid,
    input  logic                                    m_tready,
    output logic [BUS_WIDTH_IN_SYMB*SYMB_WIDTH-1:0] m_tdata,
    output logic [BUS_WIDTH_IN_SYMB-1:0]            m_tkeep,
    output logic                                    m_tlast,
    output logic                                    len_err
);
    localparam int BW         = BUS_WIDTH_IN_SYMB;
    localparam int SW         = SYMB_WIDTH;
    localparam int PAR_BEATS  = (ROOTS_NUM + BW - 1) / BW;
    localparam int LAST_LANES = ROOTS_NUM - (PAR_BEATS - 1) * BW;
    localparam int PCW        = $clog2(PAR_BEATS + 1);
    localparam logic [BW-1:0] LAST_KEEP = {BW{1'b1}} >> (BW - LAST_LANES);

    typedef enum logic {MSG, PAR} state_t;

    state_t                             state_q, state_d;
    logic [ROOTS_NUM-1:0][SW-1:0]       lfsr_q, lfsr_shift;
    logic [BW:0][ROOTS_NUM-1:0][SW-1:0] lfsr_chain;
    logic [BW*SW-1:0]                   par_beat;
    logic [PCW-1:0]                     par_cnt_q;
    logic                               rdy_en_q;
    logic                               out_free, s_fire, m_fire, par_load, par_last, frame_done;

    // Lanes are chained so lane 0 (earliest symbol) is applied first
    assign lfsr_chain[0] = lfsr_q;
    for (genvar i = 0; i < BW; i++) begin : g_lane
        rs_enc_lane u_lane (
            .en    (s_tkeep[i]),
            .d     (s_tdata[i*SW +: SW]),
            .r_in  (lfsr_chain[i]),
            .r_out (lfsr_chain[i+1])
        );
    end

    // Parity leaves from the top of the LFSR, highest degree on lane 0
    always_comb begin
        par_beat   = '0;
        lfsr_shift = '0;
        for (int k = 0; k < BW; k++) par_beat[k*SW +: SW] = lfsr_q[ROOTS_NUM-1-k];
        for (int j = BW; j < ROOTS_NUM; j++) lfsr_shift[j] = lfsr_q[j-BW];
    end

    assign par_last = (par_cnt_q == PCW'(PAR_BEATS - 1));

    always_comb begin
        out_free   = ~m_tvalid | m_tready;
        m_fire     = m_tvalid & m_tready;
        state_d    = state_q;
        s_tready   = 1'b0;
        par_load   = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            MSG: begin
                s_tready = rdy_en_q & out_free;
                if (s_tready & s_tvalid & s_tlast) state_d = PAR;
            end
            PAR: begin
                frame_done = m_fire & m_tlast;
                par_load   = out_free & (par_cnt_q != PCW'(PAR_BEATS));
                if (frame_done) state_d = MSG;
            end
            default: state_d = MSG;
        endcase
        s_fire = s_tready & s_tvalid;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= MSG;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdy_en_q  <= 1'b0;
            lfsr_q    <= '0;
            par_cnt_q <= '0;
            m_tvalid  <= 1'b0;
            m_tdata   <= '0;
            m_tkeep   <= '0;
            m_tlast   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            if (s_fire) begin
                lfsr_q   <= lfsr_chain[BW];
                m_tvalid <= 1'b1;
                m_tdata  <= s_tdata;
                m_tkeep  <= s_tkeep;
                m_tlast  <= 1'b0;
            end else if (par_load) begin
                lfsr_q    <= lfsr_shift;
                par_cnt_q <= par_cnt_q + PCW'(1);
                m_tvalid  <= 1'b1;
                m_tdata   <= par_beat;
                m_tkeep   <= par_last ? LAST_KEEP : {BW{1'b1}};
                m_tlast   <= par_last;
            end else if (frame_done) begin
                lfsr_q    <= '0;
                par_cnt_q <= '0;
                m_tvalid  <= 1'b0;
                m_tlast   <= 1'b0;
            end else if (m_fire) begin
                m_tvalid <= 1'b0;
            end
        end
    end

`ifdef RS_ENC_LEN_CHECK_EN
    localparam int CW  = $clog2(K_LEN + 2);
    localparam int BSW = $clog2(BW + 1);

    logic [CW-1:0]  sym_cnt_q, sym_sum;
    logic [BSW-1:0] beat_syms;
    int             sum_i;

    // Count saturates just past K_LEN so long frames cannot wrap back into range
    always_comb begin
        beat_syms = '0;
        for (int i = 0; i < BW; i++) beat_syms = beat_syms + BSW'(s_tkeep[i]);
        sum_i   = int'(sym_cnt_q) + int'(beat_syms);
        sym_sum = (sum_i > K_LEN) ? CW'(K_LEN + 1) : CW'(sum_i);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sym_cnt_q <= '0;
            len_err   <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (s_fire) begin
                if (s_tlast) begin
                    sym_cnt_q <= '0;
                    len_err   <= (sym_sum == '0) || (sym_sum > CW'(K_LEN));
                end else begin
                    sym_cnt_q <= sym_sum;
                end
            end
        end
    end
`else
    assign len_err = 1'b0;
`endif
endmodule

// File: tb/tb_rs_enc.sv
// Scoreboard bench for rs_enc: echoed message beats are compared exactly, parity
// via exact values (all-zero frames) and zero syndromes at alpha^1..alpha^16.
module tb_rs_enc;
    localparam int BW = 4;
    localparam int NR = 16;
    localparam int K  = 239;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [BW*8-1:0] s_tdata = '0, m_tdata;
    logic [BW-1:0] s_tkeep = '0, m_tkeep;
    logic          m_tvalid, m_tready = 1'b1, m_tlast, len_err;

    rs_enc dut (
        .clk(clk), .rstn(rstn),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BW*8-1:0] data;
        logic [BW-1:0]   keep;
        logic            last;
        bit              chk_data;
        bit              msg_last;
        bit              syn_chk;
        int              cw_len;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] cw_q[$];
    int         tests = 0, fails = 0;
    int         gexp[0:254];
    int         glog[0:255];
    bit         stall_en = 1'b0;
    bit         syn_chk_en = 1'b1;
    bit         in_par = 1'b0;
    int         par_rdy_bad = 0;
    int         len_err_cnt = 0;
    exp_t       e;
    bit         syn_ok;
    int         syn;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    always @(posedge clk) begin
        #1;
        m_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        if (rstn) begin
            if (len_err) len_err_cnt++;
            if (in_par && s_tready) par_rdy_bad++;
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_data) check("beat_data", m_tdata, e.data);
                    check("beat_keep_last", {m_tkeep, m_tlast}, {e.keep, e.last});
                    for (int k = 0; k < BW; k++) if (m_tkeep[k]) cw_q.push_back(m_tdata[k*8 +: 8]);
                    if (e.msg_last) in_par = 1'b1;
                    if (e.last) begin
                        if (e.syn_chk) begin
                            syn_ok = 1'b1;
                            for (int i = 1; i <= NR; i++) begin
                                syn = 0;
                                foreach (cw_q[n]) syn = gmul(syn, gexp[i]) ^ int'(cw_q[n]);
                                if (syn != 0) syn_ok = 1'b0;
                            end
                            check("syndrome_zero", syn_ok, 1);
                        end
                        check("cw_len", cw_q.size(), e.cw_len);
                        check("par_s_tready_low", par_rdy_bad, 0);
                        cw_q.delete();
                        par_rdy_bad = 0;
                        in_par = 1'b0;
                    end
                end
            end
        end
    end

    // kind: 0 all-zero, 1 single leading 0x01 then zeros, 2 random
    task automatic send_frame(input int nsym, input int kind, input int stop_beat);
        int nbeats, w;
        logic [BW*8-1:0] d;
        logic [BW-1:0]   kp;
        bit last;
        nbeats = (nsym + BW - 1) / BW;
        for (int b = 0; b < nbeats; b++) begin
            if (b == stop_beat) return;
            d  = '0;
            kp = '0;
            for (int k = 0; k < BW; k++) begin
                if (b * BW + k < nsym) begin
                    kp[k] = 1'b1;
                    if (kind == 2) d[k*8 +: 8] = 8'($urandom);
                    else if (kind == 1 && b == 0 && k == 0) d[k*8 +: 8] = 8'h01;
                end else begin
                    d[k*8 +: 8] = 8'hA5;   // unkept lanes carry garbage that must be ignored
                end
            end
            last = (b == nbeats - 1);
            if (stall_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            s_tvalid = 1'b1;
            s_tdata  = d;
            s_tkeep  = kp;
            s_tlast  = last;
            w = 0;
            @(negedge clk);
            while (!s_tready && w < 2000) begin w++; @(negedge clk); end
            if (!s_tready) begin
                check("s_tready_timeout", 0, 1);
                s_tvalid = 1'b0;
                return;
            end
            exp_q.push_back('{d, kp, 1'b0, 1'b1, last, 1'b0, 0});
            if (last) begin
                for (int p = 0; p < 4; p++)
                    exp_q.push_back('{'0, 4'hF, (p == 3), (kind == 0), 1'b0, syn_chk_en, nsym + NR});
            end
            @(posedge clk); #1;
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 5000) begin @(posedge clk); w++; end
        check("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11D;
        end
        glog[0] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_keep_last_err", {m_tkeep, m_tlast, len_err}, 0);
        check("rst_s_tready", s_tready, 0);
        rstn = 1'b1;
        @(posedge clk); #1;

        send_frame(K, 0, -1);
        drain();

        // x^16 mod g: zero syndromes force parity == g15..g0
        send_frame(1, 1, -1);
        repeat (5) @(negedge clk);
        check("par_latency_tlast", {m_tvalid, m_tlast}, 2'b11);
        @(negedge clk);
        check("ready_after_frame", s_tready, 1);
        drain();

        for (int f = 0; f < 100; f++) begin
            stall_en = (f >= 50);
            send_frame(K, 2, -1);
        end
        drain();
        stall_en = 1'b0;
        @(posedge clk); #1;

        send_frame(K, 2, 30);
        rstn = 1'b0;
        #1;
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_m_tdata", m_tdata, 0);
        check("midrst_keep_last_err", {m_tkeep, m_tlast, len_err}, 0);
        check("midrst_s_tready", s_tready, 0);
        exp_q.delete();
        cw_q.delete();
        in_par = 1'b0;
        par_rdy_bad = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        send_frame(K, 2, -1);
        drain();

`ifdef RS_ENC_LEN_CHECK_EN
        len_err_cnt = 0;
        send_frame(K, 2, -1);
        drain();
        check("len_err_239", len_err_cnt, 0);
        syn_chk_en = 1'b0;
        send_frame(K + 1, 2, -1);
        drain();
        syn_chk_en = 1'b1;
        check("len_err_240", len_err_cnt, 1);
`else
        check("len_err_tied", len_err_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
